// File: rtl/swi_event_encoder.sv
// Debounces NBITS asynchronous switch inputs and queues one {level, index} event
// per accepted level change into a small FIFO drained with a valid/ready handshake.
module swi_event_encoder #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk_2,
    input  logic                          reset_n,
    input  logic [NBITS-1:0]              swi,
    output logic [NBITS-1:0]              stable,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [3:0]                    ev_code,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [NBITS-1:0] sync1_r, sync2_r, stable_r, pending_r;
    logic [7:0]       cnt_r      [NBITS];
    logic [7:0]       cnt_next_s [NBITS];
    logic [NBITS-1:0] flip_s, clr_s, pending_next_s;
    logic             overflow_r, ovf_set_s;

    logic [3:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [AW:0]      count_r, count_next_s;
    logic [3:0]       code_r, push_data_s, head_next_s;
    logic             valid_r;
    logic             has_pend_s, push_s, pop_s, full_s;
    logic [2:0]       push_idx_s;

    // Per-bit debounce: count mismatch cycles, accept the new level on the last one.
    always_comb begin
        for (int i = 0; i < NBITS; i++) begin
            flip_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
            if ((sync2_r[i] != stable_r[i]) && !flip_s[i]) begin
                cnt_next_s[i] = cnt_r[i] + 8'd1;
            end else begin
                cnt_next_s[i] = 8'd0;
            end
        end
    end

    // Lowest-index pending bit wins the single push slot of this cycle.
    always_comb begin
        has_pend_s = 1'b0;
        push_idx_s = 3'd0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            has_pend_s = has_pend_s | pending_r[i];
            push_idx_s = pending_r[i] ? 3'(i) : push_idx_s;
        end
    end

    // Handshake, pending bookkeeping and next FIFO head.
    always_comb begin
        pop_s       = valid_r && ev_ready;
        full_s      = (count_r == COUNT_FULL);
        push_s      = has_pend_s && (!full_s || pop_s);
        push_data_s = {stable_r[push_idx_s], push_idx_s};
        clr_s       = push_s ? ({{(NBITS-1){1'b0}}, 1'b1} << push_idx_s) : {NBITS{1'b0}};
        // A new flip on a bit being pushed re-arms its flag rather than overflowing.
        pending_next_s = (pending_r & ~clr_s) | flip_s;
        ovf_set_s      = |(flip_s & pending_r & ~clr_s);
        rd_next_s      = rd_ptr_r + AW'(pop_s);
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW + 1)'(1);
            2'b01:   count_next_s = count_r - (AW + 1)'(1);
            default: count_next_s = count_r;
        endcase
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Synchronizers, debounce counters, stable levels, pending flags, sticky overflow.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r    <= {NBITS{1'b0}};
            sync2_r    <= {NBITS{1'b0}};
            stable_r   <= {NBITS{1'b0}};
            pending_r  <= {NBITS{1'b0}};
            overflow_r <= 1'b0;
            for (int i = 0; i < NBITS; i++) cnt_r[i] <= 8'd0;
        end else begin
            sync1_r    <= swi;
            sync2_r    <= sync1_r;
            stable_r   <= stable_r ^ flip_s;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_r | ovf_set_s;
            for (int i = 0; i < NBITS; i++) cnt_r[i] <= cnt_next_s[i];
        end
    end

    // Event FIFO storage, pointers, occupancy and registered head.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            code_r   <= 4'd0;
            valid_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            code_r   <= head_next_s;
            valid_r  <= (count_next_s != {(AW+1){1'b0}});
        end
    end

    assign stable   = stable_r;
    assign ev_valid = valid_r;
    assign ev_code  = code_r;
    assign ev_count = count_r;
    assign overflow = overflow_r;

endmodule
